// File: rtl/aes_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES
// InvMixColumns engine.
package aes_pkg;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] GF_POLY = 8'h1B;

    // Column coefficients, row-0 coefficient in the top byte. Row r uses the
    // same set rotated: coefficient j multiplies byte (r + j) mod 4.
    localparam logic [3:0][7:0] INV_COEFS = 32'h0e0b0d09;
    localparam logic [3:0][7:0] FWD_COEFS = 32'h02030101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Byte times constant; every AES mix coefficient fits in the low nibble.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column_if.sv
// Input/output valid-ready handshake bundle for the InvMixColumns engine.
interface inv_mix_column_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             mode_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        output data_i, valid_i, mode_i, ready_i,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, mode_i, ready_i,
        output ready_o, data_o, valid_o
    );
endinterface

// File: rtl/inv_mix_col_word.sv
// Combinational single-column (32-bit) MixColumns / InvMixColumns transform.
// Row 0 byte sits in the column MSB. Forward mode exists only when
// INV_MIX_FWD_EN is defined; otherwise the mode input is ignored.
module inv_mix_col_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        mode,
    output logic [31:0] col_out
);

    // Packed index 3 holds row 0, so row r lives at index 3 - r.
    logic [3:0][7:0] a;
    logic [3:0][7:0] y;

    assign a       = col_in;
    assign col_out = y;

`ifdef INV_MIX_FWD_EN
    logic [3:0][7:0] x2;
    logic [3:0][7:0] x4;
    logic [3:0][7:0] x8;
    logic [3:0][7:0] coefs;

    // Pick one coefficient from the shared xtime chain of a byte.
    function automatic logic [7:0] sel_mul(
        input logic [3:0] c,
        input logic [7:0] m1,
        input logic [7:0] m2,
        input logic [7:0] m4,
        input logic [7:0] m8
    );
        return (c[0] ? m1 : 8'h00) ^ (c[1] ? m2 : 8'h00) ^
               (c[2] ? m4 : 8'h00) ^ (c[3] ? m8 : 8'h00);
    endfunction

    assign coefs = mode ? FWD_COEFS : INV_COEFS;

    // One xtime chain per byte, shared by the forward and inverse matrices.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
    end

    // Each output row is the XOR of four coefficient-weighted bytes.
    always_comb begin
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                y[2'(3 - r)] = y[2'(3 - r)] ^ sel_mul(coefs[2'(3 - j)][3:0],
                                                      a[2'(3 - r - j)],
                                                      x2[2'(3 - r - j)],
                                                      x4[2'(3 - r - j)],
                                                      x8[2'(3 - r - j)]);
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Inverse-only: constant coefficients, the multipliers fold to XOR trees.
    always_comb begin
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                y[2'(3 - r)] = y[2'(3 - r)] ^
                               gf_mul_const(a[2'(3 - r - j)], INV_COEFS[2'(3 - j)][3:0]);
            end
        end
    end
`endif

endmodule

// File: rtl/inv_mix_column.sv
// Iterative AES InvMixColumns engine: one column per clock, four columns per
// block, results returned over a valid/ready handshake.
// Optional macro INV_MIX_FWD_EN: per-block forward (MixColumns) mode via mode_i.
//
// state | meaning
// IDLE  | waiting for a block, ready_o = 1
// BUSY  | transforming column col (0..3)
// DONE  | result held on data_o with valid_o = 1 until ready_i
module inv_mix_column
    import aes_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    inv_mix_column_if.slave bus
);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      col_q;
    logic [3:0][31:0] work_q;
    logic [3:0][31:0] result_q;
    logic            accept;
    logic            mode_eff;
    logic [31:0]     col_in;
    logic [31:0]     col_out;

`ifdef INV_MIX_FWD_EN
    logic            mode_q;
    assign mode_eff = mode_q;
`else
    assign mode_eff = 1'b0;
`endif

    // ready_o depends on ready_i only, never on valid_i.
    assign bus.ready_o = (state_q == IDLE) || ((state_q == DONE) && bus.ready_i);
    assign bus.valid_o = (state_q == DONE);
    assign bus.data_o  = result_q;
    assign accept      = bus.valid_i && bus.ready_o;

    // Column 0 is the top word, so column c sits at packed index 3 - c.
    assign col_in = work_q[2'd3 - col_q];

    inv_mix_col_word u_word (
        .col_in  (col_in),
        .mode    (mode_eff),
        .col_out (col_out)
    );

    // Next-state logic; a DONE handshake may chain straight into a new block.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (col_q == 2'd3) state_d = DONE;
            DONE: begin
                if (bus.ready_i) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Work/result registers and column counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q    <= 2'd0;
            work_q   <= '0;
            result_q <= '0;
`ifdef INV_MIX_FWD_EN
            mode_q   <= 1'b0;
`endif
        end else if (accept) begin
            col_q  <= 2'd0;
            work_q <= bus.data_i;
`ifdef INV_MIX_FWD_EN
            mode_q <= bus.mode_i;
`endif
        end else if (state_q == BUSY) begin
            result_q[2'd3 - col_q] <= col_out;
            col_q                  <= col_q + 2'd1;
        end
    end

endmodule
